// File: rtl/apb_pkg.sv
// Shared FSM encoding and default parameter values for the APB slave memory.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 256;
    localparam int DEF_WAIT_STATES = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_e;

    // Per-transfer wait count: the live input wins when flagged valid.
    function automatic logic [3:0] pick_wait(
        input logic       cfg_vld,
        input logic [3:0] cfg,
        input logic [3:0] dflt
    );
        return cfg_vld ? cfg : dflt;
    endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word storage for apb_slave_mem: one synchronous byte-enabled write port and
// one asynchronous read port sharing a single word address. No reset.
module apb_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         PCLK,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    // Contents start at zero and are never touched by the bus reset.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

    always_ff @(posedge PCLK) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a word memory with programmable wait states.
// Define APB_SLAVE_MEM_PSTRB_EN to add the PSTRB port and byte-masked writes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
// ST_WAIT | access phase, PREADY low while the wait counter runs down
// ST_DONE | access phase, PREADY high; write commits on the exit edge
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_MEM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    input  logic [3:0]              wait_cfg,
    input  logic                    wait_cfg_vld,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]     strb_q;

    logic                  setup;
    logic                  commit;
    logic [3:0]            wait_sel;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  in_range;
    logic [NBYTES-1:0]     strb_in;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_we;

`ifdef APB_SLAVE_MEM_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    // Any set bit above the word index makes the address out of range.
    assign word_addr = PADDR >> ADDR_LSB;
    assign in_range  = (word_addr < ADDR_WIDTH'(MEM_DEPTH));
    assign wait_sel  = pick_wait(wait_cfg_vld, wait_cfg, 4'(WAIT_STATES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!PENABLE) begin
                    setup = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    commit  = write_q && !err_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (setup) begin
            cnt_d   = wait_sel;
            state_d = (wait_sel == 4'd0) ? ST_DONE : ST_WAIT;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= (state_d == ST_DONE);
            if (setup) begin
                idx_q   <= PADDR[ADDR_LSB +: IDX_W];
                write_q <= PWRITE;
                err_q   <= !in_range;
                wdata_q <= PWDATA;
                strb_q  <= strb_in;
            end
        end
    end

    assign mem_we = commit && !PRESET;

    apb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .PCLK  (PCLK),
        .we    (mem_we),
        .be    (strb_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pready_q && err_q;
    assign PRDATA  = (pready_q && !err_q && !write_q) ? rdata : '0;

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, values 8/16/32: PRDATA/PWDATA width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, power of two: number of DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15: reset value of the wait register.
REQ-005 SHALL have ports PCLK in 1, system clock; PRESET in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in ADDR_WIDTH, PWDATA in DATA_WIDTH: APB request.
REQ-007 SHALL have port PSTRB in DATA_WIDTH/8: write byte strobes; present only with APB_SLAVE_MEM_PSTRB_EN.
REQ-008 SHALL have ports PRDATA out DATA_WIDTH, PREADY out 1, PSLVERR out 1: APB response.
REQ-009 SHALL have port wait_cfg in 4: per-transfer wait-state count, used when wait_cfg_vld is 1.
REQ-010 SHALL have port wait_cfg_vld in 1: 1 selects wait_cfg, 0 selects WAIT_STATES.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, DONE; registered PREADY is 1 only in DONE.
REQ-012 SHALL, in IDLE, on an edge sampling PSEL=1, PENABLE=0: latch PADDR, PWRITE, PWDATA, PSTRB; load wait counter N (wait_cfg or WAIT_STATES); go to DONE if N=0, else WAIT.
REQ-013 SHALL, in WAIT, decrement the counter each edge and go to DONE on the edge where it reaches 1; access phase therefore lasts N+1 cycles, PREADY=0 for the first N.
REQ-014 SHALL, in DONE, return to IDLE on the next edge, or re-enter the REQ-012 setup path if that edge samples PSEL=1, PENABLE=0 (back-to-back transfers).
REQ-015 SHALL compute word index = PADDR >> log2(DATA_WIDTH/8); address in range when index < MEM_DEPTH and all upper PADDR bits are 0.
REQ-016 SHALL, for out-of-range address, drive PSLVERR=1 with PREADY=1 in DONE, leave memory unchanged, drive PRDATA=0.
REQ-017 SHALL, for an in-range read, drive PRDATA=mem[index] and PSLVERR=0 in DONE; PRDATA=0 outside DONE.
REQ-018 SHALL commit an in-range write on the edge leaving DONE, and only if PSEL=PENABLE=1 at that edge.
REQ-019 SHALL abort on any edge in WAIT or DONE that samples PSEL=0: go to IDLE, no memory write, PREADY=0.
REQ-020 SHALL ignore PADDR/PWDATA/PWRITE changes after setup; latched values govern the transfer.
REQ-021 SHALL hold PSLVERR=0 whenever PREADY=0.

Reset
REQ-022 SHALL, on an edge with PRESET=1, set state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, counter=0, overriding any transfer in flight (no write committed).
REQ-023 SHALL zero memory at time 0 only; PRESET SHALL NOT alter memory contents.

Configuration
REQ-024 SHALL, with APB_SLAVE_MEM_PSTRB_EN defined, write only bytes whose PSTRB bit is 1; PSTRB=0 completes with PSLVERR=0 and no change.
REQ-025 SHALL, without APB_SLAVE_MEM_PSTRB_EN, omit PSTRB and write all bytes of the word.

Structure
REQ-026 SHALL take the FSM state enum and default parameter constants from shared package apb_pkg.
REQ-027 SHALL place storage in sub-module apb_slave_mem_array (one synchronous byte-enabled write port, one asynchronous read port, parameters DATA_WIDTH, MEM_DEPTH).

Verification
REQ-028 SHALL cover: WAIT_STATES=0, write 0xDEADBEEF to 0x10, read 0x10 -> PREADY=1 in first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-029 SHALL cover: wait_cfg_vld=1, wait_cfg=3, read -> PREADY low exactly 3 access cycles, high on the 4th.
REQ-030 SHALL cover: MEM_DEPTH=256, DATA_WIDTH=32, write to 0x400 -> PSLVERR=1 with PREADY=1, then read 0x000 returns prior value unchanged.
REQ-031 SHALL cover: with APB_SLAVE_MEM_PSTRB_EN, word 0x11223344, write 0xAABBCCDD PSTRB=0b0101 -> read returns 0x11BB33DD.
REQ-032 SHALL cover: PRESET=1 during WAIT of a write with wait_cfg=5 -> next cycle PREADY=0, PRDATA=0, target word unchanged.
REQ-033 SHALL cover: PSEL dropped mid-WAIT -> IDLE, no write; immediate back-to-back reads at 0x0 and 0x4 each complete correctly.
